vdp_port_ctrl: RTL and testbench

VDP_PORT_CTRL -- requirements
Module: vdp_port_ctrl

---
 rtl/vdp_port_ctrl.sv | 102 ++++++++++
 tb/tb_vdp_port_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_port_ctrl.sv
// VDP CPU port controller: two-byte control writes, auto-incrementing data writes to VRAM/CRAM.
// Optional VDP_REGWR_EN macro enables register writes on code-2 control words.
module vdp_port_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  wrdata,
    input  logic        ctrl_wr,
    input  logic        data_wr,
    input  logic        ctrl_rd,
    output logic [4:0]  cram_addr,
    output logic [7:0]  cram_wrdata,
    output logic        cram_wren,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wrdata,
    output logic        vram_wren,
    output logic [3:0]  reg_idx,
    output logic [7:0]  reg_data,
    output logic        reg_wr,
    output logic [1:0]  code
);

    localparam logic [0:0] ST_FIRST  = 1'b0;
    localparam logic [0:0] ST_SECOND = 1'b1;

    logic [13:0] addr_q;
    logic [1:0]  code_q;
    logic [0:0]  state_q;

    assign code = code_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            code_q      <= '0;
            state_q     <= ST_FIRST;
            cram_addr   <= '0;
            cram_wrdata <= '0;
            cram_wren   <= 1'b0;
            vram_addr   <= '0;
            vram_wrdata <= '0;
            vram_wren   <= 1'b0;
        end else begin
            // Strobes default low; address/data outputs keep their last value.
            cram_wren <= 1'b0;
            vram_wren <= 1'b0;
            if (data_wr) begin
                if (code_q == 2'd3) begin
                    cram_wren   <= 1'b1;
                    cram_addr   <= addr_q[4:0];
                    cram_wrdata <= wrdata;
                end else begin
                    vram_wren   <= 1'b1;
                    vram_addr   <= addr_q;
                    vram_wrdata <= wrdata;
                end
                addr_q  <= addr_q + 14'd1;
                state_q <= ST_FIRST;
            end else if (ctrl_wr) begin
                if (state_q == ST_FIRST) begin
                    addr_q[7:0] <= wrdata;
                    state_q     <= ctrl_rd ? ST_FIRST : ST_SECOND;
                end else begin
                    addr_q[13:8] <= wrdata[5:0];
                    code_q       <= wrdata[7:6];
                    state_q      <= ST_FIRST;
                end
            end else if (ctrl_rd) begin
                state_q <= ST_FIRST;
            end
        end
    end

`ifdef VDP_REGWR_EN
    logic [7:0] first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= '0;
            reg_wr   <= 1'b0;
            reg_idx  <= '0;
            reg_data <= '0;
        end else begin
            reg_wr <= 1'b0;
            if (!data_wr && ctrl_wr) begin
                if (state_q == ST_FIRST) begin
                    first_q <= wrdata;
                end else if (wrdata[7:6] == 2'd2) begin
                    reg_wr   <= 1'b1;
                    reg_idx  <= wrdata[3:0];
                    reg_data <= first_q;
                end
            end
        end
    end
`else
    assign reg_wr   = 1'b0;
    assign reg_idx  = '0;
    assign reg_data = '0;
`endif

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Directed self-checking bench for vdp_port_ctrl; register-write expectations follow VDP_REGWR_EN.
module tb_vdp_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  wrdata = '0;
    logic        ctrl_wr = 1'b0;
    logic        data_wr = 1'b0;
    logic        ctrl_rd = 1'b0;
    logic [4:0]  cram_addr;
    logic [7:0]  cram_wrdata;
    logic        cram_wren;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wrdata;
    logic        vram_wren;
    logic [3:0]  reg_idx;
    logic [7:0]  reg_data;
    logic        reg_wr;
    logic [1:0]  code;

    int n_tests = 0;
    int n_fail  = 0;

    vdp_port_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wrdata(wrdata),
        .ctrl_wr(ctrl_wr), .data_wr(data_wr), .ctrl_rd(ctrl_rd),
        .cram_addr(cram_addr), .cram_wrdata(cram_wrdata), .cram_wren(cram_wren),
        .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_wren(vram_wren),
        .reg_idx(reg_idx), .reg_data(reg_data), .reg_wr(reg_wr), .code(code)
    );

    always #5 clk = ~clk;

    // One bus cycle: drive on the falling edge, then settle 1 time unit after the rising edge.
    task automatic bus(input logic cw, input logic dw, input logic cr, input logic [7:0] d);
        @(negedge clk);
        ctrl_wr = cw; data_wr = dw; ctrl_rd = cr; wrdata = d;
        @(posedge clk);
        #1;
        ctrl_wr = 1'b0; data_wr = 1'b0; ctrl_rd = 1'b0; wrdata = '0;
    endtask

    function automatic logic [63:0] all_outs();
        return {12'd0, cram_addr, cram_wrdata, cram_wren, vram_addr, vram_wrdata,
                vram_wren, reg_idx, reg_data, reg_wr, code};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if (all_outs() !== 64'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (all_outs() !== 64'd0) begin
            n_fail++; $display("FAIL reset_release_idle: got %h want 0", all_outs());
        end
    endtask

    task automatic test_cram();
        bus(1, 0, 0, 8'h05);
        bus(1, 0, 0, 8'hC0);
        n_tests++;
        if (code !== 2'd3 || cram_wren !== 1'b0) begin
            n_fail++; $display("FAIL cram_code: code=%0d wren=%b want 3/0", code, cram_wren);
        end
        bus(0, 1, 0, 8'h2A);
        n_tests++;
        if (cram_wren !== 1'b1 || cram_addr !== 5'd5 || cram_wrdata !== 8'h2A || vram_wren !== 1'b0) begin
            n_fail++; $display("FAIL cram_write: wren=%b addr=%0d data=%h vwren=%b want 1/5/2a/0",
                               cram_wren, cram_addr, cram_wrdata, vram_wren);
        end
        bus(0, 0, 0, 8'h00);
        n_tests++;
        if (cram_wren !== 1'b0 || cram_addr !== 5'd5 || cram_wrdata !== 8'h2A) begin
            n_fail++; $display("FAIL cram_hold: wren=%b addr=%0d data=%h want 0/5/2a",
                               cram_wren, cram_addr, cram_wrdata);
        end
        bus(0, 1, 0, 8'h33);
        n_tests++;
        if (cram_wren !== 1'b1 || cram_addr !== 5'd6 || cram_wrdata !== 8'h33) begin
            n_fail++; $display("FAIL cram_incr: wren=%b addr=%0d data=%h want 1/6/33",
                               cram_wren, cram_addr, cram_wrdata);
        end
    endtask

    task automatic test_vram_wrap();
        bus(1, 0, 0, 8'hFF);
        bus(1, 0, 0, 8'h7F);
        n_tests++;
        if (code !== 2'd1) begin
            n_fail++; $display("FAIL vram_code: got %0d want 1", code);
        end
        bus(0, 1, 0, 8'h11);
        n_tests++;
        if (vram_wren !== 1'b1 || vram_addr !== 14'h3FFF || vram_wrdata !== 8'h11 || cram_wren !== 1'b0) begin
            n_fail++; $display("FAIL vram_top: wren=%b addr=%h data=%h cwren=%b want 1/3fff/11/0",
                               vram_wren, vram_addr, vram_wrdata, cram_wren);
        end
        bus(0, 1, 0, 8'h22);
        n_tests++;
        if (vram_wren !== 1'b1 || vram_addr !== 14'h0000 || vram_wrdata !== 8'h22) begin
            n_fail++; $display("FAIL vram_wrap: wren=%b addr=%h data=%h want 1/0000/22",
                               vram_wren, vram_addr, vram_wrdata);
        end
        bus(0, 0, 0, 8'h00);
        n_tests++;
        if (vram_wren !== 1'b0 || vram_addr !== 14'h0000 || vram_wrdata !== 8'h22) begin
            n_fail++; $display("FAIL vram_hold: wren=%b addr=%h data=%h want 0/0000/22",
                               vram_wren, vram_addr, vram_wrdata);
        end
    endtask

    task automatic test_regwr();
        logic       exp_wr;
        logic [3:0] exp_idx;
        logic [7:0] exp_data;
`ifdef VDP_REGWR_EN
        exp_wr = 1'b1; exp_idx = 4'd7; exp_data = 8'h81;
`else
        exp_wr = 1'b0; exp_idx = 4'd0; exp_data = 8'h00;
`endif
        bus(1, 0, 0, 8'h81);
        n_tests++;
        if (reg_wr !== 1'b0) begin
            n_fail++; $display("FAIL regwr_first_byte: reg_wr=%b want 0", reg_wr);
        end
        bus(1, 0, 0, 8'h87);
        n_tests++;
        if (reg_wr !== exp_wr || reg_idx !== exp_idx || reg_data !== exp_data || code !== 2'd2) begin
            n_fail++; $display("FAIL regwr_pulse: wr=%b idx=%0d data=%h code=%0d want %b/%0d/%h/2",
                               reg_wr, reg_idx, reg_data, code, exp_wr, exp_idx, exp_data);
        end
        bus(0, 1, 0, 8'h44);
        n_tests++;
        if (reg_wr !== 1'b0 || vram_wren !== 1'b1 || vram_addr !== 14'h0781 || vram_wrdata !== 8'h44) begin
            n_fail++; $display("FAIL regwr_after: reg_wr=%b vwren=%b vaddr=%h vdata=%h want 0/1/0781/44",
                               reg_wr, vram_wren, vram_addr, vram_wrdata);
        end
    endtask

    task automatic test_ctrl_rd();
        bus(1, 0, 0, 8'h10);
        bus(0, 0, 1, 8'h00);
        bus(1, 0, 0, 8'h20);
        bus(1, 0, 0, 8'h40);
        n_tests++;
        if (code !== 2'd1) begin
            n_fail++; $display("FAIL ctrlrd_code: got %0d want 1", code);
        end
        bus(0, 1, 0, 8'h5A);
        n_tests++;
        if (vram_wren !== 1'b1 || vram_addr !== 14'h0020) begin
            n_fail++; $display("FAIL ctrlrd_addr: wren=%b addr=%h want 1/0020", vram_wren, vram_addr);
        end
        // Control write and read together: byte consumed, sequence returns to first byte.
        bus(1, 0, 1, 8'h34);
        bus(1, 0, 0, 8'h12);
        bus(1, 0, 0, 8'h40);
        bus(0, 1, 0, 8'h6B);
        n_tests++;
        if (code !== 2'd1 || vram_wren !== 1'b1 || vram_addr !== 14'h0012) begin
            n_fail++; $display("FAIL ctrlwr_rd_same: code=%0d wren=%b addr=%h want 1/1/0012",
                               code, vram_wren, vram_addr);
        end
    endtask

    task automatic test_simul();
        bus(1, 0, 0, 8'h1F);
        bus(1, 0, 0, 8'hC0);
        bus(1, 1, 0, 8'h55);
        n_tests++;
        if (cram_wren !== 1'b1 || cram_addr !== 5'd31 || cram_wrdata !== 8'h55 || code !== 2'd3) begin
            n_fail++; $display("FAIL simul_cram: wren=%b addr=%0d data=%h code=%0d want 1/31/55/3",
                               cram_wren, cram_addr, cram_wrdata, code);
        end
        bus(0, 1, 0, 8'h66);
        n_tests++;
        if (cram_wren !== 1'b1 || cram_addr !== 5'd0 || cram_wrdata !== 8'h66) begin
            n_fail++; $display("FAIL simul_incr: wren=%b addr=%0d data=%h want 1/0/66",
                               cram_wren, cram_addr, cram_wrdata);
        end
        bus(1, 0, 0, 8'h1F);
        bus(1, 0, 0, 8'hC0);
        bus(1, 1, 0, 8'h55);
        bus(1, 0, 0, 8'h09);
        bus(1, 0, 0, 8'h40);
        n_tests++;
        if (code !== 2'd1) begin
            n_fail++; $display("FAIL simul_state_first: code=%0d want 1", code);
        end
        bus(0, 1, 0, 8'h01);
        n_tests++;
        if (vram_wren !== 1'b1 || vram_addr !== 14'h0009) begin
            n_fail++; $display("FAIL simul_state_addr: wren=%b addr=%h want 1/0009", vram_wren, vram_addr);
        end
    endtask

    task automatic test_reset_mid();
        bus(1, 0, 0, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (all_outs() !== 64'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %h want 0", all_outs());
        end
        @(posedge clk); #1;
        n_tests++;
        if (all_outs() !== 64'd0) begin
            n_fail++; $display("FAIL reset_mid_held: got %h want 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus(1, 0, 0, 8'h03);
        bus(1, 0, 0, 8'hC0);
        n_tests++;
        if (code !== 2'd3) begin
            n_fail++; $display("FAIL reset_mid_code: got %0d want 3", code);
        end
        bus(0, 1, 0, 8'h77);
        n_tests++;
        if (cram_wren !== 1'b1 || cram_addr !== 5'd3 || cram_wrdata !== 8'h77) begin
            n_fail++; $display("FAIL reset_mid_addr: wren=%b addr=%0d data=%h want 1/3/77",
                               cram_wren, cram_addr, cram_wrdata);
        end
    endtask

    initial begin
        test_reset();
        test_cram();
        test_vram_wrap();
        test_regwr();
        test_ctrl_rd();
        test_simul();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
